// File: rtl/mem_word_ctrl.sv
// Word-to-byte access controller for the byte-wide mem32 array: one 32-bit command at a time, four little-endian beats.
// Optional bound check on the request address is enabled with `define MEM_WORD_CTRL_BOUND_CHK_EN.
module mem_word_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

`ifdef MEM_WORD_CTRL_BOUND_CHK_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif
  // Highest start address whose four bytes all fit inside the array.
  localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_DEPTH - 4);

  state_t      state, next_state;
  logic        accept;
  logic        oob;
  logic        is_wr;
  logic [1:0]  beat;
  logic [23:0] wdata_q;

  assign req_ready = rst && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign oob       = BOUND_EN && (req_addr > LAST_OK);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = oob ? RESP : XFER;
      XFER:    if (beat == 2'd3) next_state = is_wr ? RESP : DRAIN;
      DRAIN:   next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      is_wr     <= 1'b0;
      beat      <= '0;
      wdata_q   <= '0;
    end else begin
      mem_wr <= 1'b0;
      mem_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_wr <= req_wr;
            beat  <= '0;
            if (oob) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              // Beat 0 is launched from the handshake edge so it appears in the first XFER cycle.
              mem_wr    <= req_wr;
              mem_rd    <= !req_wr;
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata[7:0];
              wdata_q   <= req_wdata[31:8];
            end
          end
        end
        XFER: begin
          // Read data trails its strobe by a cycle; bytes shift in from the top, LSB first.
          if (!is_wr && beat != 2'd0) rsp_rdata <= {mem_rdata, rsp_rdata[31:8]};
          if (beat == 2'd3) begin
            if (is_wr) rsp_valid <= 1'b1;
          end else begin
            beat      <= beat + 2'd1;
            mem_wr    <= is_wr;
            mem_rd    <= !is_wr;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= wdata_q[7:0];
            wdata_q   <= {8'h00, wdata_q[23:8]};
          end
        end
        DRAIN: begin
          rsp_rdata <= {mem_rdata, rsp_rdata[31:8]};
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_word_ctrl.md
# mem_word_ctrl

Word-access initiator for the byte-wide `mem32` storage array. It accepts one 32-bit read or write command at a time on a valid/ready request port. It splits each command into four little-endian byte accesses on the memory strobes (`wr`, `rd`, `addr`, `Data_in`). For reads it reassembles the returned bytes into a word and presents it on a valid/ready response port. It sits between the core-side load/store logic and the memory, and it is the only master that drives the memory strobes.

## Interface
- `ADDR_W`, 32: width of request and memory byte addresses.
- `MEM_DEPTH`, 11: number of bytes in the attached array; used only by the bound check.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  command present.
- `req_ready`  out  1  controller can accept a command.
- `req_wr`  in  1  1 = write word, 0 = read word.
- `req_addr`  in  ADDR_W  byte address of the word's least-significant byte.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  response present; held until accepted.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  32  read data; 0 for write responses.
- `rsp_err`  out  1  command rejected (bound check only).
- `mem_wr`  out  1  byte write strobe.
- `mem_rd`  out  1  byte read strobe.
- `mem_addr`  out  ADDR_W  byte address.
- `mem_wdata`  out  8  byte write data.
- `mem_rdata`  in  8  byte read data; valid in the cycle after the `mem_rd` beat that requested it.

## Operation
- FSM states: IDLE, XFER, DRAIN, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch `req_wr`, `req_addr` and `req_wdata`, clear the beat counter, and go to XFER.
- XFER: four beats, i = 0..3, one per cycle.
  - `mem_addr` = latched addr + i, modulo 2^ADDR_W (wraps at the top).
  - Write: `mem_wr` = 1, `mem_wdata` = wdata[8i+7:8i].
  - Read: `mem_rd` = 1.
  - After beat 3: a write goes to RESP; a read goes to DRAIN.
- Read capture: the `mem_rdata` sampled one cycle after beat i is stored to rdata[8i+7:8i].
  - Captures for beats 0–2 happen in XFER.
  - The capture for beat 3 happens in DRAIN.
  - DRAIN lasts exactly one cycle, then goes to RESP.
- RESP:
  - `rsp_valid` = 1, with `rsp_rdata` and `rsp_err` stable.
  - When `rsp_ready` = 1: go to IDLE and clear `rsp_rdata` and `rsp_err`.
  - `rsp_ready` asserted in any other state is ignored.
- Only one command is outstanding at a time; `req_ready` = 0 in XFER, DRAIN and RESP.
- `mem_wr` and `mem_rd` are never high in the same cycle.
- Outside XFER: `mem_wr` = `mem_rd` = 0, and `mem_addr`/`mem_wdata` hold their last value.
- Reset:
  - Every output is 0 while `rst` = 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `mem_wr`, `mem_rd`, `mem_addr`, `mem_wdata`.
  - The FSM goes to IDLE.
  - `req_ready` rises in the first cycle with `rst` = 1.
  - Reset asserted mid-command abandons the command: no further strobes and no response. Bytes already written stay written.
- The `req_*` inputs are ignored outside IDLE.

## Timing
- Cycle 0: request handshake in IDLE.
- Write:
  - Beats on cycles 1–4.
  - `rsp_valid` from cycle 5.
  - Minimum 6 cycles per command, including the response handshake cycle.
- Read:
  - `mem_rd` beats on cycles 1–4.
  - `mem_rdata` is captured on cycles 2–5.
  - `rsp_valid` from cycle 6.
- Next command can be accepted one cycle after the response handshake.
- All outputs are registered except `req_ready`, which is decoded from the state and `rst`.

## Configuration
- Macro: `MEM_WORD_CTRL_BOUND_CHK_EN`.
- Defined:
  - In IDLE, a command with `req_addr` > MEM_DEPTH−4 is accepted but produces no strobes.
  - The FSM goes directly to RESP with `rsp_err` = 1 and `rsp_rdata` = 0; `rsp_valid` is high from cycle 1.
  - In-range commands behave as described above.
- Undefined:
  - No check; `rsp_err` is tied to 0.
  - Every command performs four beats, and addresses wrap modulo 2^ADDR_W.

## Test plan
- Reset and write:
  - Stimulus: `rst` = 0 for 3 cycles, then write addr=0, data=0xDEADBEEF.
  - Response: all outputs 0 during reset.
  - Response: `mem_wr` beats at addr 0,1,2,3 carrying 0xEF, 0xBE, 0xAD, 0xDE.
  - Response: `rsp_valid` at cycle 5 with `rsp_rdata` = 0.
- Read back:
  - Stimulus: read addr=0 against a memory model holding the bytes above.
  - Response: `mem_rd` beats on cycles 1–4 and `rsp_rdata` = 0xDEADBEEF at cycle 6.
- Unaligned read with backpressure:
  - Stimulus: read addr=5 with model bytes 5..8 = 0x11, 0x22, 0x33, 0x44; hold `rsp_ready` = 0 for 4 cycles.
  - Response: `rsp_rdata` = 0x44332211 held stable, `req_ready` = 0, and no new strobes while waiting.
- Address wrap:
  - Stimulus: write addr=0xFFFFFFFE with the macro undefined.
  - Response: `mem_addr` = 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Bound check:
  - Stimulus: with `MEM_WORD_CTRL_BOUND_CHK_EN` defined, read addr=8 (MEM_DEPTH=11).
  - Response: no `mem_rd` beats, and `rsp_valid` with `rsp_err` = 1 at cycle 1.
- Reset mid-write:
  - Stimulus: drop `rst` after beat 1 of a write.
  - Response: strobes stop immediately, no response is issued, and `req_ready` = 1 in the first cycle after `rst` returns high.
